// File: rtl/rng_stream_gen.sv
// Multi-lane xorshift32 word stream with counted or free-running runs; valid one cycle after start.
// rand_num_data is the live lane state; it only advances on an accepted handshake and holds while stalled.
module rng_stream_gen #(
  parameter int          LANES     = 1,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] SEED_BASE = 32'h2545F491
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [CNT_W-1:0]      count,
  input  logic                  stop,
  input  logic                  seed_load,
  input  logic [31:0]           seed_data,
  output logic [32*LANES-1:0]   rand_num_data,
  output logic                  rand_num_valid,
  input  logic                  rand_num_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic [31:0] xorshift32(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  // Lanes are decorrelated by the golden-ratio constant; an all-zero state would lock xorshift at zero.
  function automatic logic [31:0] lane_seed(input logic [31:0] s, input int idx);
    logic [31:0] k;
    logic [31:0] v;
    k = 32'(idx) * 32'h9E3779B9;
    v = s ^ k;
    return (v == 32'h0) ? 32'h00000001 : v;
  endfunction

  state_t           state_q, state_d;
  logic             valid_q, valid_d;
  logic             busy_q,  busy_d;
  logic             done_q,  done_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [31:0]      lane_q [LANES];
  logic [31:0]      lane_d [LANES];

  logic accept;
  assign accept = valid_q & rand_num_ready;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    lane_d  = lane_q;
    case (state_q)
      S_IDLE: begin
        // Seed is applied on the same edge as start, so the run opens on the new seed.
        if (seed_load) begin
          for (int i = 0; i < LANES; i++) lane_d[i] = lane_seed(seed_data, i);
        end
        if (start) begin
          state_d = S_RUN;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          cnt_d   = count;
        end
      end
      S_RUN: begin
        if (accept) begin
          for (int i = 0; i < LANES; i++) lane_d[i] = xorshift32(lane_q[i]);
          // Zero counter in RUN means free-run, so it is never decremented.
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        end
        if (stop || (accept && cnt_q == CNT_W'(1))) begin
          state_d = S_DONE;
          valid_d = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      for (int i = 0; i < LANES; i++) lane_q[i] <= lane_seed(SEED_BASE, i);
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      lane_q  <= lane_d;
    end
  end

  always_comb begin
    rand_num_data = '0;
    for (int i = 0; i < LANES; i++) rand_num_data[32*i +: 32] = lane_q[i];
  end

  assign rand_num_valid = valid_q;
  assign busy           = busy_q;
  assign done           = done_q;

  ap_hold_on_stall: assert property (@(posedge clock) disable iff (reset)
    (rand_num_valid && !rand_num_ready) |=> $stable(rand_num_data));

  ap_done_not_busy: assert property (@(posedge clock) disable iff (reset)
    done |-> !busy);

endmodule

// File: tb/tb_rng_stream_gen.sv
// Bench for rng_stream_gen: a one-lane and a two-lane instance share stimulus and are checked against a word-level model.
module tb_rng_stream_gen;

  localparam logic [31:0] SEED_BASE = 32'h2545F491;
  localparam logic [31:0] GOLD      = 32'h9E3779B9;

  logic        clock = 1'b0;
  logic        reset, start, stop, seed_load, rdy;
  logic [15:0] count;
  logic [31:0] seed_data;

  logic [31:0] d1;
  logic        v1, b1, dn1;
  logic [63:0] d2;
  logic        v2, b2, dn2;

  rng_stream_gen #(.LANES(1), .CNT_W(16), .SEED_BASE(SEED_BASE)) u_dut1 (
    .clock(clock), .reset(reset), .start(start), .count(count), .stop(stop),
    .seed_load(seed_load), .seed_data(seed_data), .rand_num_data(d1),
    .rand_num_valid(v1), .rand_num_ready(rdy), .busy(b1), .done(dn1)
  );

  rng_stream_gen #(.LANES(2), .CNT_W(16), .SEED_BASE(SEED_BASE)) u_dut2 (
    .clock(clock), .reset(reset), .start(start), .count(count), .stop(stop),
    .seed_load(seed_load), .seed_data(seed_data), .rand_num_data(d2),
    .rand_num_valid(v2), .rand_num_ready(rdy), .busy(b2), .done(dn2)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] xs(input logic [31:0] x);
    logic [31:0] y;
    y = x;
    y = y ^ (y << 13);
    y = y ^ (y >> 17);
    y = y ^ (y << 5);
    return y;
  endfunction

  function automatic logic [31:0] lseed(input logic [31:0] s, input int i);
    logic [31:0] v;
    v = s ^ (32'(i) * GOLD);
    return (v == 32'h0) ? 32'h1 : v;
  endfunction

  // Word-level model: is a run open, is this the done cycle, words still owed, current lane words.
  bit          m_running;
  bit          m_ending;
  int          m_left;
  logic [31:0] m_lane [2];

  always @(posedge clock or posedge reset) begin : model
    bit took;
    bit last;
    if (reset) begin
      m_running = 1'b0;
      m_ending  = 1'b0;
      m_left    = 0;
      m_lane[0] = lseed(SEED_BASE, 0);
      m_lane[1] = lseed(SEED_BASE, 1);
    end else if (m_running) begin
      took = rdy;
      last = took && (m_left == 1);
      if (took) begin
        m_lane[0] = xs(m_lane[0]);
        m_lane[1] = xs(m_lane[1]);
        if (m_left > 0) m_left = m_left - 1;
      end
      if (stop || last) begin
        m_running = 1'b0;
        m_ending  = 1'b1;
      end
    end else if (m_ending) begin
      m_ending = 1'b0;
    end else begin
      if (seed_load) begin
        m_lane[0] = lseed(seed_data, 0);
        m_lane[1] = lseed(seed_data, 1);
      end
      if (start) begin
        m_running = 1'b1;
        m_left    = int'(count);
      end
    end
  end

  bit cmp_en = 1'b0;

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("valid1", v1, m_running);
      chk("busy1",  b1, m_running);
      chk("done1",  dn1, m_ending);
      chk("data1",  d1, m_lane[0]);
      chk("valid2", v2, m_running);
      chk("busy2",  b2, m_running);
      chk("done2",  dn2, m_ending);
      chk("data2",  d2, {m_lane[1], m_lane[0]});
    end
  end

  logic [31:0] acc_q[$];
  int          done_cnt;

  always @(negedge clock) begin
    if (v1 && rdy) acc_q.push_back(d1);
    if (dn1) done_cnt++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!dn1 && n < budget) begin
      tick();
      n++;
    end
    chk(name, dn1, 1'b1);
  endtask

  task automatic chk_acc(input string name, input int idx, input logic [31:0] exp);
    if (acc_q.size() > idx) chk(name, acc_q[idx], exp);
    else                    chk(name, 64'(acc_q.size()), 64'(idx + 1));
  endtask

  initial begin
    logic [31:0] held;
    int          n;
    start = 0; stop = 0; seed_load = 0; seed_data = 0; count = 0; rdy = 0; reset = 0;
    done_cnt = 0;
    #1 reset = 1;
    repeat (3) tick();
    chk("rst_valid", v1, 1'b0);
    chk("rst_busy",  b1, 1'b0);
    chk("rst_done",  dn1, 1'b0);
    chk("rst_data1", d1, 32'h2545F491);
    chk("rst_data2", d2, 64'hBB728D28_2545F491);
    reset = 0;
    cmp_en = 1'b1;
    tick();

    // Reseed to 1 with start, two counted words.
    acc_q.delete(); done_cnt = 0;
    seed_load = 1; seed_data = 32'h1; start = 1; count = 2; rdy = 1;
    tick();
    seed_load = 0; start = 0;
    chk("r31_first_data", d1, 32'h00000001);
    wait_done("r31_done_seen", 20);
    chk("r31_words", 64'(acc_q.size()), 2);
    chk_acc("r31_w0", 0, 32'h00000001);
    chk_acc("r31_w1", 1, 32'h00042021);
    tick();
    chk("r31_valid_after", v1, 1'b0);
    chk("r31_done_once", 64'(done_cnt), 1);

    // Continuity: restart without reseed; start and seed_load pulsed mid-run are ignored.
    acc_q.delete(); done_cnt = 0;
    start = 1; count = 3;
    tick();
    start = 0;
    chk("r36_first_data", d1, 32'h04080601);
    tick();
    start = 1; count = 1; seed_load = 1; seed_data = 32'h12345678;
    tick();
    start = 0; seed_load = 0;
    wait_done("r36_done_seen", 20);
    chk("r36_words", 64'(acc_q.size()), 3);
    chk_acc("r36_w0", 0, 32'h04080601);
    tick();
    stop = 1;
    tick();
    stop = 0;
    chk("idle_stop_ignored", v1, 1'b0);

    // Stall for five cycles, then accept the same word.
    acc_q.delete();
    rdy = 0; start = 1; count = 2;
    tick();
    start = 0;
    held = m_lane[0];
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("r32_valid_hold", v1, 1'b1);
      chk("r32_data_hold", d1, held);
    end
    rdy = 1;
    wait_done("r32_done_seen", 20);
    chk("r32_words", 64'(acc_q.size()), 2);
    chk_acc("r32_w0", 0, held);
    tick();

    // Free-run, stop together with the 11th handshake.
    acc_q.delete(); done_cnt = 0;
    rdy = 1; count = 0; start = 1;
    tick();
    start = 0;
    n = 0;
    while (acc_q.size() < 10 && n < 100) begin
      tick();
      n++;
    end
    chk("r33_ten_accepts", 64'(acc_q.size()), 10);
    stop = 1;
    tick();
    stop = 0;
    chk("r33_words", 64'(acc_q.size()), 11);
    chk("r33_valid_low", v1, 1'b0);
    chk("r33_done_high", dn1, 1'b1);
    tick();
    chk("r33_done_once", 64'(done_cnt), 1);

    // Two lanes: second lane seed collapses to zero and is replaced.
    rdy = 0; seed_load = 1; seed_data = GOLD; start = 1; count = 1;
    tick();
    seed_load = 0; start = 0;
    chk("r34_lane0", d2[31:0], 32'h9E3779B9);
    chk("r34_lane1", d2[63:32], 32'h00000001);
    chk("r34_single", d1, 32'h9E3779B9);
    rdy = 1;
    wait_done("r34_done_seen", 20);
    tick();

    // Reset in the middle of a long counted run.
    done_cnt = 0;
    rdy = 1; count = 100; start = 1;
    tick();
    start = 0;
    repeat (5) tick();
    reset = 1;
    #1;
    chk("r35_valid", v1, 1'b0);
    chk("r35_busy",  b1, 1'b0);
    chk("r35_done",  dn1, 1'b0);
    chk("r35_data1", d1, 32'h2545F491);
    chk("r35_data2", d2, 64'hBB728D28_2545F491);
    tick();
    tick();
    reset = 0;
    repeat (5) tick();
    chk("r35_no_done", 64'(done_cnt), 0);
    chk("r35_no_valid", v1, 1'b0);
    acc_q.delete();
    start = 1; count = 1;
    tick();
    start = 0;
    wait_done("r35_done_seen", 20);
    chk_acc("r35_first_word", 0, 32'h2545F491);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
